// File: rtl/spio_wifi_itr_capture_pkg.sv
// ---------------------------------------------------------------------------
// spio_wifi_itr_capture_pkg
//   Shared definitions for the WiFi interrupt capture block: the debounce
//   state enumeration, the default build-time parameters and the width of
//   the debounce tick counter.
// ---------------------------------------------------------------------------
package spio_wifi_itr_capture_pkg;

  // Debounce states: two stable levels, each with a "checking" state that
  // counts ticks toward the opposite level.
  typedef enum logic [1:0] {
    STABLE_OFF = 2'd0,
    CHECK_ON   = 2'd1,
    STABLE_ON  = 2'd2,
    CHECK_OFF  = 2'd3
  } deb_state_t;

  localparam int DEFAULT_BW_SYNC        = 2;
  localparam int DEFAULT_DEBOUNCE_TICKS = 4;
  localparam int DEFAULT_BW_COUNT       = 8;

  // Wide enough for any DEBOUNCE_TICKS in 1..255.
  localparam int DEB_CNT_W = 8;

endpackage

// File: rtl/spio_itr_debounce.sv
// ---------------------------------------------------------------------------
// spio_itr_debounce
//   Synchronizes an asynchronous interrupt pin, normalizes its polarity so
//   that 1 means asserted, and filters it into a stable level plus a
//   one-cycle event marking each accepted off-to-on transition.
//
//   Build option: SPIO_WIFI_ITR_DEBOUNCE_EN
//     defined   - a four-state debounce FSM requires DEBOUNCE_TICKS
//                 consecutive tick_gpio samples before accepting a change.
//     undefined - the synchronized level is used directly; the event is its
//                 rising edge and tick_gpio / DEBOUNCE_TICKS are ignored.
//
// Ports
//   clk          in   block clock
//   rst          in   synchronous active-high reset
//   tick_gpio    in   single-cycle sampling strobe
//   pin          in   asynchronous pin input
//   stable_level out  filtered level (1 = asserted)
//   event_pulse  out  one-cycle pulse on each accepted assertion
// ---------------------------------------------------------------------------
module spio_itr_debounce
  import spio_wifi_itr_capture_pkg::*;
#(
  parameter int BW_SYNC        = DEFAULT_BW_SYNC,
  parameter int DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS,
  parameter int ACTIVE_HIGH    = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_gpio,
  input  logic pin,
  output logic stable_level,
  output logic event_pulse
);

  // Pin level that means "not asserted"; the synchronizer resets to it so a
  // reset never looks like an assertion.
  localparam logic INACTIVE_PIN = (ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;

  logic [BW_SYNC-1:0] sync_q;
  logic               level;

  // Synchronizer chain; bit 0 takes the raw pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {BW_SYNC{INACTIVE_PIN}};
    end else begin
      sync_q <= {sync_q[BW_SYNC-2:0], pin};
    end
  end

  // XOR with the inactive level turns an active-low pin into active-high.
  assign level = sync_q[BW_SYNC-1] ^ INACTIVE_PIN;

`ifdef SPIO_WIFI_ITR_DEBOUNCE_EN

  localparam logic [DEB_CNT_W-1:0] TICKS_TARGET = DEB_CNT_W'(DEBOUNCE_TICKS);
  localparam logic [DEB_CNT_W-1:0] CNT_ONE      = DEB_CNT_W'(1);

  deb_state_t           state_q, state_d;
  logic [DEB_CNT_W-1:0] cnt_q, cnt_d;
  logic [DEB_CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + CNT_ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= STABLE_OFF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter holds the number of consecutive ticks already seen at the
  // new level. The first differing tick counts as one, so with a target of 1
  // the stable states switch directly without visiting a check state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    event_pulse = 1'b0;
    if (tick_gpio) begin
      case (state_q)
        STABLE_OFF: begin
          if (level) begin
            if (TICKS_TARGET == CNT_ONE) begin
              state_d     = STABLE_ON;
              cnt_d       = '0;
              event_pulse = 1'b1;
            end else begin
              state_d = CHECK_ON;
              cnt_d   = CNT_ONE;
            end
          end
        end
        CHECK_ON: begin
          if (level) begin
            if (cnt_inc == TICKS_TARGET) begin
              state_d     = STABLE_ON;
              cnt_d       = '0;
              event_pulse = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = STABLE_OFF;
            cnt_d   = '0;
          end
        end
        STABLE_ON: begin
          if (!level) begin
            if (TICKS_TARGET == CNT_ONE) begin
              state_d = STABLE_OFF;
              cnt_d   = '0;
            end else begin
              state_d = CHECK_OFF;
              cnt_d   = CNT_ONE;
            end
          end
        end
        CHECK_OFF: begin
          if (!level) begin
            if (cnt_inc == TICKS_TARGET) begin
              state_d = STABLE_OFF;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = STABLE_ON;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = STABLE_OFF;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // While checking the off transition the pin is still considered on.
  assign stable_level = (state_q == STABLE_ON) || (state_q == CHECK_OFF);

`else

  logic       level_q;
  logic       unused_tick;
  logic [7:0] unused_ticks;

  // Previous synchronized level for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  assign stable_level = level;
  assign event_pulse  = level & ~level_q;
  assign unused_tick  = tick_gpio;
  assign unused_ticks = 8'(DEBOUNCE_TICKS);

`endif

endmodule

// File: rtl/spio_wifi_itr_capture.sv
// ---------------------------------------------------------------------------
// spio_wifi_itr_capture
//   Captures interrupt events from the WiFi module pin into a sticky pending
//   flag, a saturating event counter and an overflow flag, and raises an
//   interrupt request while pending and enabled.
//
//   Build option: SPIO_WIFI_ITR_DEBOUNCE_EN (see spio_itr_debounce) selects
//   tick-based debouncing of the pin; without it events are raw rising edges
//   of the synchronized pin.
//
// Ports
//   clk           in   block clock
//   rst           in   synchronous active-high reset
//   tick_gpio     in   single-cycle sampling strobe shared with GPIO blocks
//   wifi_itr_pin  in   asynchronous interrupt pin from the WiFi module
//   itr_enable    in   allows capture and interrupt output
//   itr_clear     in   single-cycle clear pulse from the register bank
//   itr_pending   out  sticky pending flag
//   itr_count     out  saturating count of captured events since last clear
//   itr_overflow  out  an event arrived while itr_count was saturated
//   interrupt     out  interrupt request to the platform controller
// ---------------------------------------------------------------------------
module spio_wifi_itr_capture
  import spio_wifi_itr_capture_pkg::*;
#(
  parameter int BW_SYNC        = DEFAULT_BW_SYNC,
  parameter int DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS,
  parameter int BW_COUNT       = DEFAULT_BW_COUNT,
  parameter int ACTIVE_HIGH    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick_gpio,
  input  logic                wifi_itr_pin,
  input  logic                itr_enable,
  input  logic                itr_clear,
  output logic                itr_pending,
  output logic [BW_COUNT-1:0] itr_count,
  output logic                itr_overflow,
  output logic                interrupt
);

  localparam logic [BW_COUNT-1:0] COUNT_MAX = {BW_COUNT{1'b1}};
  localparam logic [BW_COUNT-1:0] COUNT_ONE = BW_COUNT'(1);

  logic unused_stable_level;
  logic itr_event;
  logic accept;

  spio_itr_debounce #(
    .BW_SYNC        (BW_SYNC),
    .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
    .ACTIVE_HIGH    (ACTIVE_HIGH)
  ) u_debounce (
    .clk          (clk),
    .rst          (rst),
    .tick_gpio    (tick_gpio),
    .pin          (wifi_itr_pin),
    .stable_level (unused_stable_level),
    .event_pulse  (itr_event)
  );

  // Events seen while disabled are dropped entirely.
  assign accept = itr_event & itr_enable;

  // A clear coinciding with an event leaves that event as the only one
  // recorded, so software never loses an assertion that races its clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      itr_pending  <= 1'b0;
      itr_count    <= '0;
      itr_overflow <= 1'b0;
    end else if (itr_clear) begin
      itr_pending  <= accept;
      itr_count    <= accept ? COUNT_ONE : '0;
      itr_overflow <= 1'b0;
    end else if (accept) begin
      itr_pending <= 1'b1;
      if (itr_count == COUNT_MAX) begin
        itr_overflow <= 1'b1;
      end else begin
        itr_count <= itr_count + COUNT_ONE;
      end
    end
  end

  assign interrupt = itr_pending & itr_enable;

endmodule

// File: tb/tb_spio_wifi_itr_capture.sv
// ---------------------------------------------------------------------------
// tb_spio_wifi_itr_capture
//   Self-checking bench for spio_wifi_itr_capture with default parameters.
//   A behavioural model (delay line plus run-length debounce and integer
//   counters) predicts every output each cycle; directed scenarios add
//   explicit checks for latency, no-event glitches, saturation, clear/event
//   collision, disabled capture and reset during a debounce check.
// ---------------------------------------------------------------------------
module tb_spio_wifi_itr_capture;

  localparam int TB_SYNC   = 2;
  localparam int TB_TICKS  = 4;
  localparam int COUNT_MAX = 255;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_gpio;
  logic       wifi_itr_pin;
  logic       itr_enable;
  logic       itr_clear;
  logic       itr_pending;
  logic [7:0] itr_count;
  logic       itr_overflow;
  logic       interrupt;

  int n_compared   = 0;
  int n_mismatched = 0;
  int cycle_no     = 0;
  bit tick_random  = 1'b0;

  // Reference model state
  logic [TB_SYNC-1:0] m_sync;
  bit                 m_stable;
  int                 m_run;
  bit                 m_prev;
  bit                 m_pending;
  int                 m_count;
  bit                 m_overflow;

  spio_wifi_itr_capture #(
    .BW_SYNC        (TB_SYNC),
    .DEBOUNCE_TICKS (TB_TICKS),
    .BW_COUNT       (8),
    .ACTIVE_HIGH    (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick_gpio    (tick_gpio),
    .wifi_itr_pin (wifi_itr_pin),
    .itr_enable   (itr_enable),
    .itr_clear    (itr_clear),
    .itr_pending  (itr_pending),
    .itr_count    (itr_count),
    .itr_overflow (itr_overflow),
    .interrupt    (interrupt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Would the design emit an event this cycle, given the model state and the
  // current tick? The visible level is the oldest delay-line entry.
  function automatic bit predict_event();
    bit level;
    level = m_sync[TB_SYNC-1];
`ifdef SPIO_WIFI_ITR_DEBOUNCE_EN
    if (!tick_gpio || level == m_stable) return 1'b0;
    return level && (m_run + 1 == TB_TICKS);
`else
    return level && !m_prev;
`endif
  endfunction

  task automatic model_reset();
    m_sync     = '0;
    m_stable   = 1'b0;
    m_run      = 0;
    m_prev     = 1'b0;
    m_pending  = 1'b0;
    m_count    = 0;
    m_overflow = 1'b0;
  endtask

  // Drive one cycle, advance the model across the edge, then compare.
  task automatic applyStimulus(input bit pin, input bit en, input bit clr, input bit r);
    bit ev;
    bit level;
    bit accepted;
    wifi_itr_pin = pin;
    itr_enable   = en;
    itr_clear    = clr;
    rst          = r;
    tick_gpio    = tick_random ? ($urandom_range(0, 2) == 0) : (cycle_no % 4 == 0);
    ev    = predict_event();
    level = m_sync[TB_SYNC-1];
    if (r) begin
      model_reset();
    end else begin
`ifdef SPIO_WIFI_ITR_DEBOUNCE_EN
      if (tick_gpio) begin
        if (level != m_stable) begin
          m_run++;
          if (m_run == TB_TICKS) begin
            m_stable = level;
            m_run    = 0;
          end
        end else begin
          m_run = 0;
        end
      end
`else
      m_prev = level;
`endif
      accepted = ev && en;
      if (clr) begin
        m_pending  = accepted;
        m_count    = accepted ? 1 : 0;
        m_overflow = 1'b0;
      end else if (accepted) begin
        m_pending = 1'b1;
        if (m_count == COUNT_MAX) m_overflow = 1'b1;
        else m_count++;
      end
      m_sync = {m_sync[TB_SYNC-2:0], pin};
    end
    @(posedge clk);
    #1;
    cycle_no++;
    checkOutput("cyc_pending",   32'(itr_pending),  32'(m_pending));
    checkOutput("cyc_count",     32'(itr_count),    32'(m_count));
    checkOutput("cyc_overflow",  32'(itr_overflow), 32'(m_overflow));
    checkOutput("cyc_interrupt", 32'(interrupt),    32'(m_pending && itr_enable));
  endtask

  task automatic run_cycles(input int n, input bit pin, input bit en);
    for (int i = 0; i < n; i++) applyStimulus(pin, en, 1'b0, 1'b0);
  endtask

  task automatic pulse(input bit en);
    run_cycles(24, 1'b1, en);
    run_cycles(24, 1'b0, en);
  endtask

  initial begin
    int  lat;
    int  bound;
    bit  found;
    bit  hit;
    bit  done;
    bit  rnd_pin;
    bit  rnd_en;
    bit  rnd_clr;
    bit  rnd_rst;

    model_reset();

    // Reset state
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("reset_pending",  32'(itr_pending),  32'd0);
    checkOutput("reset_count",    32'(itr_count),    32'd0);
    checkOutput("reset_overflow", 32'(itr_overflow), 32'd0);
    checkOutput("reset_irq",      32'(interrupt),    32'd0);
    run_cycles(8, 1'b0, 1'b1);

    // Latency from pin rise to pending
`ifdef SPIO_WIFI_ITR_DEBOUNCE_EN
    bound = TB_SYNC + 4 * TB_TICKS + 1;
`else
    bound = TB_SYNC + 1;
`endif
    found = 1'b0;
    lat   = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      if (!found) lat++;
      if (itr_pending) found = 1'b1;
    end
    checkOutput("latency_seen",     32'(found), 32'd1);
    checkOutput("latency_in_bound", 32'(lat <= bound), 32'd1);
    checkOutput("single_count",     32'(itr_count), 32'd1);
    checkOutput("single_irq",       32'(interrupt), 32'd1);
    run_cycles(40, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("clear_pending", 32'(itr_pending), 32'd0);

    // Short glitch: two ticks high only
    run_cycles(8, 1'b1, 1'b1);
    run_cycles(40, 1'b0, 1'b1);
`ifdef SPIO_WIFI_ITR_DEBOUNCE_EN
    checkOutput("glitch_pending", 32'(itr_pending), 32'd0);
    checkOutput("glitch_count",   32'(itr_count),   32'd0);
`else
    checkOutput("glitch_pending", 32'(itr_pending), 32'd1);
    checkOutput("glitch_count",   32'(itr_count),   32'd1);
`endif
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);

    // Saturation and overflow
    for (int i = 0; i < 300; i++) pulse(1'b1);
    checkOutput("sat_count",    32'(itr_count),    32'd255);
    checkOutput("sat_overflow", 32'(itr_overflow), 32'd1);
    checkOutput("sat_pending",  32'(itr_pending),  32'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("sat_clr_count",    32'(itr_count),    32'd0);
    checkOutput("sat_clr_overflow", 32'(itr_overflow), 32'd0);
    checkOutput("sat_clr_pending",  32'(itr_pending),  32'd0);

    // Event and clear in the same cycle
    pulse(1'b1);
    pulse(1'b1);
    checkOutput("pre_collide_count", 32'(itr_count), 32'd2);
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick_gpio = (cycle_no % 4 == 0);
      hit = predict_event();
      applyStimulus(1'b1, 1'b1, hit, 1'b0);
      if (hit) done = 1'b1;
    end
    checkOutput("collide_seen",     32'(done),         32'd1);
    checkOutput("collide_pending",  32'(itr_pending),  32'd1);
    checkOutput("collide_count",    32'(itr_count),    32'd1);
    checkOutput("collide_overflow", 32'(itr_overflow), 32'd0);
    run_cycles(40, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);

    // Capture disabled
    for (int i = 0; i < 3; i++) pulse(1'b0);
    checkOutput("dis_count",   32'(itr_count),   32'd0);
    checkOutput("dis_pending", 32'(itr_pending), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("dis_then_en_irq", 32'(interrupt), 32'd0);

    // Disabling keeps pending
    pulse(1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("disable_keeps_pending", 32'(itr_pending), 32'd1);
    checkOutput("disable_masks_irq",     32'(interrupt),   32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    run_cycles(40, 1'b0, 1'b1);

    // Reset during an in-progress check, pin held high throughout
    for (int i = 0; i < 30; i++) begin
`ifdef SPIO_WIFI_ITR_DEBOUNCE_EN
      if (m_run >= 2) break;
`else
      if (i >= 1) break;
`endif
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("rst_mid_count", 32'(itr_count), 32'd0);
    run_cycles(60, 1'b1, 1'b1);
    checkOutput("rst_mid_events",  32'(itr_count),   32'd1);
    checkOutput("rst_mid_pending", 32'(itr_pending), 32'd1);
    run_cycles(40, 1'b0, 1'b1);

    // Randomized traffic against the model
    tick_random = 1'b1;
    rnd_pin = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) rnd_pin = ~rnd_pin;
      rnd_en  = ($urandom_range(0, 7) != 0);
      rnd_clr = ($urandom_range(0, 39) == 0);
      rnd_rst = ($urandom_range(0, 499) == 0);
      applyStimulus(rnd_pin, rnd_en, rnd_clr, rnd_rst);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
